// File: rtl/control_adc_serial.sv
// rtl/control_adc_serial.sv - frame sequencer and deserialiser for the external serial ADC
//
// Purpose:
//   Generates a periodic sample tick. On each tick it runs one SPI-style frame:
//   CPOL=1, MSB first, N_FRAME sclk periods. The last N_DATA received bits are
//   published on dato together with a one-cycle dato_valido strobe. A tick that
//   arrives while a frame is still running is dropped and sets a sticky overrun
//   flag.
//
// Ports:
//   clk_reloj   in   system clock, all logic on posedge
//   rst_reset   in   synchronous active-high reset
//   en_enable   in   1 = run periodic conversions
//   sdata_in    in   ADC serial data, changes after sclk falls
//   cs_n        out  ADC chip select, active low
//   sclk        out  ADC serial clock, idle high
//   dato        out  last completed sample, held between frames
//   dato_valido out  one-cycle strobe when dato updates
//   ocupado     out  high while a frame is in progress
//   sobrecarga  out  sticky overrun flag, cleared only by reset
module control_adc_serial #(
  parameter int DIV_SCLK   = 2,
  parameter int SAMPLE_DIV = 2268,
  parameter int N_FRAME    = 16,
  parameter int N_DATA     = 12
) (
  input  logic              clk_reloj,
  input  logic              rst_reset,
  input  logic              en_enable,
  input  logic              sdata_in,
  output logic              cs_n,
  output logic              sclk,
  output logic [N_DATA-1:0] dato,
  output logic              dato_valido,
  output logic              ocupado,
  output logic              sobrecarga
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = (DIV_SCLK > 1) ? $clog2(DIV_SCLK) : 1;
  localparam int BW = $clog2(N_FRAME + 1);

  localparam logic [CW-1:0] CNT_TOP = CW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(DIV_SCLK - 1);
  localparam logic [BW-1:0] BIT_TOP = BW'(N_FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_QUIET,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]     r_cnt;
  logic [DW-1:0]     r_div;
  logic [BW-1:0]     r_bit;
  logic              r_sclk;
  logic              r_cs_n;
  logic [N_DATA-1:0] r_shift;
  logic [N_DATA-1:0] r_dato;
  logic              r_valid;
  logic              r_ocupado;
  logic              r_over;

  logic              w_tick;
  logic              w_div_end;
  logic [DW-1:0]     w_div_nxt;
  logic [BW-1:0]     w_bit_nxt;
  logic              w_sclk_nxt;
  logic              w_cs_n_nxt;
  logic              w_shift;
  logic              w_load;

  assign cs_n        = r_cs_n;
  assign sclk        = r_sclk;
  assign dato        = r_dato;
  assign dato_valido = r_valid;
  assign ocupado     = r_ocupado;
  assign sobrecarga  = r_over;

  // Sample-rate divider; held at zero while disabled so the first tick after
  // enabling comes a full period later.
  always_ff @(posedge clk_reloj) begin
    if (rst_reset || !en_enable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_TOP) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_tick    = en_enable && (r_cnt == CNT_TOP);
  assign w_div_end = (r_div == DIV_TOP);

  always_ff @(posedge clk_reloj) begin
    if (rst_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_div counts system clocks inside the current sclk half-period (or the
  // setup/quiet phase); it restarts from zero whenever a phase ends.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = '0;
    w_bit_nxt   = r_bit;
    w_sclk_nxt  = r_sclk;
    w_cs_n_nxt  = r_cs_n;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sclk_nxt = 1'b1;
        w_cs_n_nxt = 1'b1;
        w_bit_nxt  = '0;
        if (w_tick) begin
          w_state_nxt = S_SETUP;
          w_cs_n_nxt  = 1'b0;
        end
      end
      S_SETUP: begin
        if (w_div_end) begin
          w_state_nxt = S_SHIFT;
          w_sclk_nxt  = 1'b0;
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      S_SHIFT: begin
        if (w_div_end) begin
          w_sclk_nxt = ~r_sclk;
          // Data is captured on the edge that raises sclk, half a period
          // after the ADC updated it on the preceding fall.
          if (!r_sclk) begin
            w_shift = 1'b1;
            if (r_bit == BIT_TOP) begin
              w_bit_nxt   = '0;
              w_state_nxt = S_QUIET;
            end else begin
              w_bit_nxt = r_bit + BW'(1);
            end
          end
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      S_QUIET: begin
        if (w_div_end) begin
          w_state_nxt = S_DONE;
          w_cs_n_nxt  = 1'b1;
          w_load      = 1'b1;
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sclk_nxt  = 1'b1;
        w_cs_n_nxt  = 1'b1;
      end
    endcase
  end

  // The shift register only keeps N_DATA bits: the leading bits of a frame
  // fall off the top and are never seen on dato.
  always_ff @(posedge clk_reloj) begin
    if (rst_reset) begin
      r_div     <= '0;
      r_bit     <= '0;
      r_sclk    <= 1'b1;
      r_cs_n    <= 1'b1;
      r_shift   <= '0;
      r_dato    <= '0;
      r_valid   <= 1'b0;
      r_ocupado <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_div     <= w_div_nxt;
      r_bit     <= w_bit_nxt;
      r_sclk    <= w_sclk_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_valid   <= w_load;
      r_ocupado <= (w_state_nxt != S_IDLE);
      if (w_shift) begin
        r_shift <= {r_shift[N_DATA-2:0], sdata_in};
      end
      if (w_load) begin
        r_dato <= r_shift;
      end
      // A tick in any state other than IDLE (including DONE) is lost.
      if (w_tick && (r_state != S_IDLE)) begin
        r_over <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_adc_serial.sv
// tb/tb_control_adc_serial.sv - self-checking bench for control_adc_serial
module tb_control_adc_serial;

  localparam int D  = 2;
  localparam int NV = 6;
  localparam int FL = 1 + 33 * D;

  typedef struct {
    logic [15:0] word;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [NV];

  logic        clk = 1'b0;
  logic        en    [2];
  logic        rst   [2];
  logic        sd    [2];
  logic        cs_n_o [2];
  logic        sclk_o [2];
  logic [11:0] dato_o [2];
  logic        val_o  [2];
  logic        ocu_o  [2];
  logic        ovr_o  [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit b_done = 1'b0;

  int          m_t      [2];
  int          m_since  [2];
  int          m_nframe [2];
  bit          m_ok     [2];
  bit          m_over   [2];
  logic [11:0] m_dato   [2];
  logic [11:0] m_exp    [2];
  logic [15:0] adc_word [2];
  int          adc_idx  [2];
  logic        prev_sclk [2];

  always #5 clk = ~clk;

  control_adc_serial #(.DIV_SCLK(D), .SAMPLE_DIV(100)) dut_a (
    .clk_reloj(clk), .rst_reset(rst[0]), .en_enable(en[0]), .sdata_in(sd[0]),
    .cs_n(cs_n_o[0]), .sclk(sclk_o[0]), .dato(dato_o[0]), .dato_valido(val_o[0]),
    .ocupado(ocu_o[0]), .sobrecarga(ovr_o[0])
  );

  control_adc_serial #(.DIV_SCLK(D), .SAMPLE_DIV(50)) dut_b (
    .clk_reloj(clk), .rst_reset(rst[1]), .en_enable(en[1]), .sdata_in(sd[1]),
    .cs_n(cs_n_o[1]), .sclk(sclk_o[1]), .dato(dato_o[1]), .dato_valido(val_o[1]),
    .ocupado(ocu_o[1]), .sobrecarga(ovr_o[1])
  );

  function automatic int sdv(input int i);
    return (i == 0) ? 100 : 50;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc %0d got %0h want %0h", nm, i, cyc, act, exp);
    end
  endtask

  // Reference model: a frame is described only by its tick cycle; every output
  // is derived from the offset into the frame.
  task automatic step(input int i);
    int   o;
    logic e_cs, e_sclk, e_ocu, e_val;
    if (m_ok[i]) begin
      e_cs = 1'b1; e_sclk = 1'b1; e_ocu = 1'b0; e_val = 1'b0;
      if (m_t[i] >= 0 && cyc >= m_t[i] + 1 && cyc <= m_t[i] + FL) begin
        o = cyc - m_t[i];
        e_ocu = 1'b1;
        if (o == FL) begin
          e_val = 1'b1;
          m_dato[i] = m_exp[i];
        end else begin
          e_cs = 1'b0;
        end
        if (o >= 1 + D && o < 1 + 32 * D) e_sclk = (((o - 1 - D) / D) % 2) == 1;
      end
      chk("cs_n", i, cs_n_o[i], e_cs);
      chk("sclk", i, sclk_o[i], e_sclk);
      chk("ocupado", i, ocu_o[i], e_ocu);
      chk("valido", i, val_o[i], e_val);
      chk("dato", i, dato_o[i], m_dato[i]);
      chk("sobrecarga", i, ovr_o[i], m_over[i]);
    end
    // ADC: next bit, MSB first, after each sclk fall while selected
    if (cs_n_o[i] !== 1'b0) begin
      adc_idx[i] = 15;
    end else if (prev_sclk[i] === 1'b1 && sclk_o[i] === 1'b0) begin
      sd[i] = adc_word[i][adc_idx[i]];
      if (adc_idx[i] > 0) adc_idx[i]--;
    end
    prev_sclk[i] = sclk_o[i];
    // advance model with this cycle's inputs
    if (rst[i]) begin
      m_ok[i] = 1'b1; m_t[i] = -1; m_dato[i] = '0; m_over[i] = 1'b0;
      m_since[i] = cyc + 1;
    end else if (m_ok[i]) begin
      if (en[i]) begin
        if ((cyc - m_since[i]) % sdv(i) == sdv(i) - 1) begin
          if (m_t[i] < 0 || cyc > m_t[i] + FL) begin
            m_t[i] = cyc;
            if (i == 0 && m_nframe[i] < NV) begin
              adc_word[i] = tbl[m_nframe[i]].word;
              m_exp[i]    = tbl[m_nframe[i]].exp;
            end else begin
              adc_word[i] = 16'($urandom);
              m_exp[i]    = adc_word[i][11:0];
            end
            m_nframe[i]++;
          end else begin
            m_over[i] = 1'b1;
          end
        end
      end else begin
        m_since[i] = cyc + 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ok[i] = 1'b0; m_t[i] = -1; m_dato[i] = '0; m_over[i] = 1'b0; m_exp[i] = '0;
      m_since[i] = 0; m_nframe[i] = 0; adc_word[i] = '0; adc_idx[i] = 15;
      prev_sclk[i] = 1'b1; sd[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) step(i);
      cyc++;
    end
  end

  task automatic wait_cs(input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (cs_n_o[0] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure(output int rises, output int ocu, output int gaps_bad, output bit ok);
    logic ps;
    int   last, n;
    rises = 0; gaps_bad = 0; ok = 1'b0; last = -1; n = 0;
    ocu = (ocu_o[0] === 1'b1) ? 1 : 0;
    ps = sclk_o[0];
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (ocu_o[0] === 1'b1) ocu++;
      if (ps === 1'b0 && sclk_o[0] === 1'b1) begin
        if (last >= 0 && n - last != 2 * D) gaps_bad++;
        last = n;
        rises++;
      end
      ps = sclk_o[0];
      if (val_o[0] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_rises(input int target);
    logic ps;
    int   r, n;
    r = 0; n = 0; ps = sclk_o[0];
    while (r < target && n < 200) begin
      @(negedge clk);
      n++;
      if (ps === 1'b0 && sclk_o[0] === 1'b1) r++;
      ps = sclk_o[0];
    end
    chk("rise_budget", 0, r, target);
  endtask

  task automatic frame(input string nm, input logic [11:0] exp);
    int rises, ocu, gaps;
    bit ok;
    measure(rises, ocu, gaps, ok);
    chk({nm, "_done"}, 0, ok, 1);
    chk({nm, "_rises"}, 0, rises, 16);
    chk({nm, "_ocupado"}, 0, ocu, FL);
    chk({nm, "_spacing"}, 0, gaps, 0);
    chk({nm, "_dato"}, 0, dato_o[0], exp);
    @(negedge clk);
    chk({nm, "_strobe1"}, 0, val_o[0], 0);
  endtask

  // instance A: nominal timing, table vectors, enable drop, mid-frame reset
  initial begin
    int  n, bad, nval, cslow;
    bit  ok, seen;
    tbl[0] = '{16'h0A5C, 12'hA5C};
    tbl[1] = '{16'h0FFF, 12'hFFF};
    tbl[2] = '{16'h0000, 12'h000};
    tbl[3] = '{16'hF123, 12'h123};
    tbl[4] = '{16'h0800, 12'h800};
    tbl[5] = '{16'h5001, 12'h001};
    en[0] = 1'b0; rst[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst[0] = 1'b0;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cs_n_o[0] !== 1'b1 || sclk_o[0] !== 1'b1 || dato_o[0] !== 12'h000) bad++;
    end
    chk("idle_hold", 0, bad, 0);

    @(posedge clk); #2 en[0] = 1'b1;
    wait_cs(150, n, ok);
    chk("first_fall_ok", 0, ok, 1);
    chk("first_fall_delay", 0, n - 1, 100);

    for (int k = 0; k < NV; k++) begin
      if (k > 0) begin
        wait_cs(150, n, ok);
        chk("tbl_fall", 0, ok, 1);
      end
      frame("tbl", tbl[k].exp);
    end
    chk("no_overrun", 0, ovr_o[0], 0);

    repeat (3) begin
      wait_cs(150, n, ok);
      chk("rnd_fall", 0, ok, 1);
      frame("rnd", m_exp[0]);
    end

    wait_cs(150, n, ok);
    chk("drop_fall", 0, ok, 1);
    count_rises(8);
    @(posedge clk); #2 en[0] = 1'b0;
    nval = 0; cslow = 0; seen = 1'b0;
    repeat (600) begin
      @(negedge clk);
      if (seen && cs_n_o[0] !== 1'b1) cslow++;
      if (val_o[0] === 1'b1) begin
        nval++;
        seen = 1'b1;
      end
    end
    chk("drop_strobes", 0, nval, 1);
    chk("drop_quiet", 0, cslow, 0);

    @(posedge clk); #2 en[0] = 1'b1;
    wait_cs(150, n, ok);
    chk("rst_fall", 0, ok, 1);
    count_rises(10);
    @(posedge clk); #2 rst[0] = 1'b1;
    @(posedge clk); #2 rst[0] = 1'b0;
    @(negedge clk);
    chk("rst_cs_n", 0, cs_n_o[0], 1);
    chk("rst_sclk", 0, sclk_o[0], 1);
    chk("rst_ocupado", 0, ocu_o[0], 0);
    chk("rst_dato", 0, dato_o[0], 0);
    chk("rst_valido", 0, val_o[0], 0);
    wait_cs(150, n, ok);
    chk("post_rst_fall", 0, ok, 1);
    frame("post_rst", m_exp[0]);

    for (int k = 0; k < 1000 && !b_done; k++) @(negedge clk);
    chk("b_done", 1, b_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // instance B: tick period shorter than a frame, every other tick overruns
  initial begin
    int nval;
    en[1] = 1'b0; rst[1] = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst[1] = 1'b0;
    @(posedge clk); #2 en[1] = 1'b1;
    nval = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (val_o[1] === 1'b1) nval++;
    end
    chk("b_frames", 1, nval, 4);
    chk("b_overrun", 1, ovr_o[1], 1);
    b_done = 1'b1;
  end

endmodule
